key_scan_ctrl: RTL and testbench



---
 rtl/key_scan_pkg.sv | 16 +
 rtl/key_prio_enc.sv | 21 ++
 rtl/key_scan_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_key_scan_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// rtl/key_scan_pkg.sv - shared types and constants for the keypad scan controller.
package key_scan_pkg;

    localparam int KEY_N      = 10;
    localparam int KEY_CODE_W = 4;

    localparam logic [KEY_CODE_W-1:0] CODE_NONE = '0;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        DEB_REL
    } scan_state_t;

endpackage

// File: rtl/key_prio_enc.sv
// rtl/key_prio_enc.sv - 10-to-4 priority encoder for active-low keys; highest index wins.
module key_prio_enc
    import key_scan_pkg::*;
(
    input  logic [KEY_N-1:0]      keys_n,
    output logic                  gs,
    output logic [KEY_CODE_W-1:0] code
);

    always_comb begin
        gs   = ~&keys_n;
        code = CODE_NONE;
        // Ascending scan so the highest pressed index overwrites lower ones.
        for (int i = 0; i < KEY_N; i++) begin
            if (!keys_n[i]) begin
                code = KEY_CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/key_scan_ctrl.sv
// rtl/key_scan_ctrl.sv - keypad debounce FSM with FWFT event FIFO; KEY_SCAN_REPEAT_EN enables auto-repeat.
module key_scan_ctrl
    import key_scan_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int REPEAT_DLY   = 32,
    parameter int REPEAT_CYC   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [KEY_N-1:0]      S_n,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [KEY_CODE_W-1:0] evt_code,
    output logic                  key_held,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    logic [KEY_N-1:0]      s1, s2;
    logic                  gs;
    logic [KEY_CODE_W-1:0] code;

    scan_state_t           state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [KEY_CODE_W-1:0] cand, cand_next;
    logic                  push;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '1;
            s2 <= '1;
        end else begin
            s1 <= S_n;
            s2 <= s1;
        end
    end

    key_prio_enc u_enc (
        .keys_n (s2),
        .gs     (gs),
        .code   (code)
    );

`ifdef KEY_SCAN_REPEAT_EN
    localparam int RCNT_W = $clog2(((REPEAT_DLY > REPEAT_CYC) ? REPEAT_DLY : REPEAT_CYC) + 1);
    localparam logic [RCNT_W-1:0] RCNT_FIRST = RCNT_W'(REPEAT_DLY - 1);
    localparam logic [RCNT_W-1:0] RCNT_NEXT  = RCNT_W'(REPEAT_CYC - 1);
    logic [RCNT_W-1:0] rcnt, rcnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
        end else begin
            rcnt <= rcnt_next;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DLY, REPEAT_CYC};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= CODE_NONE;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cand  <= cand_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        push       = 1'b0;
`ifdef KEY_SCAN_REPEAT_EN
        rcnt_next  = rcnt;
`endif
        unique case (state)
            IDLE: begin
                if (gs) begin
                    cand_next  = code;
                    cnt_next   = '0;
                    state_next = DEB_PRESS;
                end
            end
            DEB_PRESS: begin
                if (!gs || code != cand) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    push       = 1'b1;
                    state_next = HELD;
`ifdef KEY_SCAN_REPEAT_EN
                    rcnt_next  = RCNT_FIRST;
`endif
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                // Code changes while held are ignored; only a full release leaves HELD.
                if (!gs) begin
                    cnt_next   = '0;
                    state_next = DEB_REL;
`ifdef KEY_SCAN_REPEAT_EN
                    rcnt_next  = '0;
                end else if (rcnt == '0) begin
                    push      = 1'b1;
                    rcnt_next = RCNT_NEXT;
                end else begin
                    rcnt_next = rcnt - 1'b1;
`endif
                end
            end
            DEB_REL: begin
                if (gs) begin
                    state_next = HELD;
`ifdef KEY_SCAN_REPEAT_EN
                    rcnt_next  = RCNT_FIRST;
`endif
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign key_held = (state == HELD) || (state == DEB_REL);

    logic [KEY_CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;
    logic [KEY_CODE_W-1:0] last_code;
    logic                  pop, full, wr_en;

    assign full  = (count == CNT_FULL);
    assign pop   = evt_valid & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= cand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_code <= CODE_NONE;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                last_code <= mem[rd_ptr];
            end
            count <= count + {{PTR_W{1'b0}}, wr_en} - {{PTR_W{1'b0}}, pop};
            if (push && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    assign evt_valid = (count != '0);
    assign evt_code  = evt_valid ? mem[rd_ptr] : last_code;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb/tb_key_scan_ctrl.sv - self-checking bench for key_scan_ctrl with a press-level event model.
module tb_key_scan_ctrl;
    import key_scan_pkg::*;

    localparam int DEB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] S_n = '1;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [3:0] evt_code;
    logic       key_held;
    logic       overflow;

    always #5 clk = ~clk;

    key_scan_ctrl #(
        .DEBOUNCE_CYC (DEB),
        .FIFO_DEPTH   (DEPTH),
        .REPEAT_DLY   (32),
        .REPEAT_CYC   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .S_n       (S_n),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    int         checks = 0;
    int         errors = 0;
    int         mq[$];
    bit         ov_m = 1'b0;
    bit         prev_stall = 1'b0;
    logic [3:0] prev_code = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] key_mask(input int k);
        logic [9:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    function automatic int top_code(input logic [9:0] m);
        for (int i = 9; i >= 0; i--) begin
            if (m[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_push(input int c);
        if (mq.size() >= DEPTH) ov_m = 1'b1;
        else mq.push_back(c);
    endtask

    // Scoreboard: every accepted event must match the oldest expected press.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                check("stall_valid", evt_valid, 1);
                check("stall_code", evt_code, prev_code);
            end
            if (evt_valid && evt_ready) begin
                if (mq.size() == 0) check("evt_unexpected", evt_valid, 0);
                else check("evt_code", evt_code, mq.pop_front());
            end
        end
        prev_stall = !rst && evt_valid && !evt_ready;
        prev_code  = evt_code;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] m;
        logic [9:0] m2;
        int gap;

        step(2);
        check("rst_valid", evt_valid, 0);
        check("rst_code", evt_code, 0);
        check("rst_held", key_held, 0);
        check("rst_ovf", overflow, 0);
        rst = 1'b0;
        step(2);

        // Clean press of key 3 with exact latency.
        evt_ready = 1'b1;
        model_push(3);
        S_n = 10'h3F7;
        step(6);
        check("lat_early", evt_valid, 0);
        step(1);
        check("lat_valid", evt_valid, 1);
        check("lat_code", evt_code, 3);
        check("lat_held", key_held, 1);
        step(1);
        check("lat_one_cycle", evt_valid, 0);
        step(10);
        S_n = '1;
        step(10);
        check("clean_held_clr", key_held, 0);

        // Bounce on key 5, then a stable press.
        model_push(5);
        for (int i = 0; i < 5; i++) begin
            S_n = ~key_mask(5);
            step(2);
            S_n = '1;
            step(2);
        end
        check("bounce_no_evt", mq.size(), 1);
        S_n = ~key_mask(5);
        step(DEB + 4);
        check("bounce_evt", mq.size(), 0);
        S_n = '1;
        step(10);

        // Priority and held-code changes.
        model_push(8);
        S_n = ~(key_mask(2) | key_mask(8));
        step(10);
        check("prio_evt", mq.size(), 0);
        S_n = ~key_mask(2);
        step(10);
        S_n = '1;
        step(10);
        model_push(2);
        S_n = ~key_mask(2);
        step(10);
        S_n = '1;
        step(10);
        check("prio_second", mq.size(), 0);

        // Backpressure and overflow.
        evt_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            model_push(k);
            S_n = ~key_mask(k);
            step(10);
            S_n = '1;
            step(10);
        end
        check("ovf_set", overflow, ov_m);
        check("ovf_valid", evt_valid, 1);
        check("ovf_head", evt_code, 0);
        evt_ready = 1'b1;
        step(6);
        check("ovf_drained", mq.size(), 0);
        check("ovf_empty", evt_valid, 0);
        check("ovf_sticky", overflow, 1);
        check("empty_hold", evt_code, 3);

        // Full FIFO with push and pop in the same cycle.
        evt_ready = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        mq.delete();
        ov_m = 1'b0;
        check("rst_ovf_clear", overflow, 0);
        for (int k = 6; k < 10; k++) begin
            model_push(k);
            S_n = ~key_mask(k);
            step(10);
            S_n = '1;
            step(10);
        end
        check("full_valid", evt_valid, 1);
        S_n = ~key_mask(1);
        step(6);
        evt_ready = 1'b1;
        step(1);
        evt_ready = 1'b0;
        model_push(1);
        check("fullpop_ovf", overflow, 0);
        check("fullpop_head", evt_code, 7);
        S_n = '1;
        step(10);
        evt_ready = 1'b1;
        step(6);
        check("fullpop_drain", mq.size(), 0);

        // Reset while key 7 is held.
        evt_ready = 1'b0;
        model_push(7);
        S_n = ~key_mask(7);
        step(10);
        check("pre_rst_valid", evt_valid, 1);
        check("pre_rst_held", key_held, 1);
        rst = 1'b1;
        step(1);
        mq.delete();
        check("midrst_valid", evt_valid, 0);
        check("midrst_code", evt_code, 0);
        check("midrst_held", key_held, 0);
        check("midrst_ovf", overflow, 0);
        rst = 1'b0;
        evt_ready = 1'b1;
        model_push(7);
        step(6);
        check("rehold_early", evt_valid, 0);
        step(1);
        check("rehold_valid", evt_valid, 1);
        check("rehold_code", evt_code, 7);
`ifdef KEY_SCAN_REPEAT_EN
        for (int k = 0; k < 3; k++) begin
            gap = (k == 0) ? 32 : 8;
            model_push(7);
            step(gap - 1);
            check("rep_early", evt_valid, 0);
            step(1);
            check("rep_valid", evt_valid, 1);
            check("rep_code", evt_code, 7);
        end
        step(2);
`else
        gap = 48;
        step(gap);
        check("no_repeat", evt_valid, 0);
`endif
        S_n = '1;
        step(12);
        check("rehold_drain", mq.size(), 0);

        // Randomised presses with bounce, held-code changes and release glitches.
        for (int n = 0; n < 40; n++) begin
            m = 10'($urandom_range(1, 1023));
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                S_n = ~m;
                step($urandom_range(1, 2));
                S_n = '1;
                step($urandom_range(1, 2));
            end
            model_push(top_code(m));
            S_n = ~m;
            for (int c = 0; c < DEB + 4; c++) begin
                evt_ready = ($urandom_range(0, 3) != 0);
                step(1);
            end
            if ($urandom_range(0, 1) == 1) begin
                m2 = 10'($urandom_range(1, 1023));
                S_n = ~m2;
                for (int c = 0; c < 8; c++) begin
                    evt_ready = ($urandom_range(0, 3) != 0);
                    step(1);
                end
            end
            evt_ready = 1'b1;
            S_n = '1;
            step(2);
            if ($urandom_range(0, 1) == 1) begin
                S_n = ~m;
                step(1);
                S_n = '1;
            end
            step(12);
        end
        check("rand_drain", mq.size(), 0);
        check("rand_ovf", overflow, ov_m);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
